// File: rtl/bin2bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
// Holds the FSM encoding, the BCD digit type and the elaboration-time size helpers.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // Largest value representable in the given number of BCD digits (10^digits - 1).
    function automatic longint unsigned max_bcd_val(input int digits);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between a value source and bin2bcd_seq.
// The ovf flag exists only when BIN2BCD_OVF_SAT_EN is defined.
interface bin2bcd_seq_if #(
    parameter int N      = 10,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [N-1:0]          bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_SAT_EN
    logic                  ovf;

    modport master (output start, bin_in, input busy, done, bcd_out, ovf);
    modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more.
// Latency: combinational. Backpressure: none.
// Stateless; one instance per BCD digit.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t nib,
    output bcd_digit_t res
);
    assign res = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock); BIN2BCD_OVF_SAT_EN adds saturation + ovf.
// Latency: N+1 cycles from accepted start to the one-cycle done pulse; back-to-back starts accepted in DONE.
// Backpressure: none; start is ignored (not queued) while busy, bcd_out holds until the next done.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int N      = 10,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int BW = 4 * DIGITS;
    localparam int W  = BW + N;
    localparam int CW = cnt_width(N);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SHIFT = ST_SHIFT;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  work;
    logic [W-1:0]  adj;
    logic [W-1:0]  shifted;
    logic [BW-1:0] bcd_q;

    // All digits are corrected in parallel before the shared left shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .nib (work[N+4*g +: 4]),
            .res (adj[N+4*g +: 4])
        );
    end

    assign adj[N-1:0] = work[N-1:0];
    // Carries out of the top digit fall off here, giving the result mod 10^DIGITS.
    assign shifted    = adj << 1;

`ifdef BIN2BCD_OVF_SAT_EN
    localparam longint unsigned MAX_VAL = max_bcd_val(DIGITS);
    logic ovf_pend;
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
            bcd_q <= '0;
`ifdef BIN2BCD_OVF_SAT_EN
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
`ifdef BIN2BCD_OVF_SAT_EN
                        bcd_q <= ovf_pend ? {DIGITS{4'h9}} : shifted[W-1:N];
                        ovf_q <= ovf_pend;
`else
                        bcd_q <= shifted[W-1:N];
`endif
                    end
                end
                default: begin
                    if (bus.start) begin
                        state <= SHIFT;
                        work  <= {{BW{1'b0}}, bus.bin_in};
                        cnt   <= CW'(N);
`ifdef BIN2BCD_OVF_SAT_EN
                        ovf_pend <= 64'(bus.bin_in) > MAX_VAL;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy    = (state == SHIFT);
    assign bus.done    = (state == DONE);
    assign bus.bcd_out = bcd_q;
`ifdef BIN2BCD_OVF_SAT_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: N=10 and N=14 instances, directed vectors with hand-computed BCD.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.N(10), .DIGITS(4)) if10 ();
    bin2bcd_seq_if #(.N(14), .DIGITS(4)) if14 ();

    bin2bcd_seq #(.N(10), .DIGITS(4)) u10 (.clk(clk), .rst(rst), .bus(if10));
    bin2bcd_seq #(.N(14), .DIGITS(4)) u14 (.clk(clk), .rst(rst), .bus(if14));

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          t;
    } exp_t;

    exp_t q10[$];
    exp_t q14[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic rst_smp = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= rst;
    end

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor for the N=10 instance: value, latency, busy length, and held output between dones.
    logic [15:0] held10 = 16'h0;
    int          busy_cnt10 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_smp) begin
            chk("reset_busy", longint'(if10.busy), 0);
            chk("reset_done", longint'(if10.done), 0);
            chk("reset_bcd",  longint'(if10.bcd_out), 0);
`ifdef BIN2BCD_OVF_SAT_EN
            chk("reset_ovf",  longint'(if10.ovf), 0);
`endif
            held10     = 16'h0;
            busy_cnt10 = 0;
        end else begin
            if (if10.busy === 1'b1) busy_cnt10++;
            if (if10.done === 1'b1) begin
                if (q10.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 bcd=%h, expected no done (cycle %0d)",
                             if10.bcd_out, cyc);
                end else begin
                    e = q10.pop_front();
                    chk("bcd10", longint'(if10.bcd_out), longint'(e.bcd));
                    chk("latency10", longint'(cyc + 1 - e.t), 11);
                    chk("busy_len10", longint'(busy_cnt10), 10);
`ifdef BIN2BCD_OVF_SAT_EN
                    chk("ovf10", longint'(if10.ovf), longint'(e.ovf));
`endif
                    held10 = e.bcd;
                end
                busy_cnt10 = 0;
            end else begin
                chk("hold10", longint'(if10.bcd_out), longint'(held10));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_smp && if14.done === 1'b1) begin
            if (q14.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done14: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
                e = q14.pop_front();
                chk("bcd14", longint'(if14.bcd_out), longint'(e.bcd));
                chk("latency14", longint'(cyc + 1 - e.t), 15);
`ifdef BIN2BCD_OVF_SAT_EN
                chk("ovf14", longint'(if14.ovf), longint'(e.ovf));
`endif
            end
        end
    end

    task automatic push10(input logic [15:0] bcd);
        exp_t e;
        e.bcd = bcd; e.ovf = 1'b0; e.t = cyc + 1;
        q10.push_back(e);
    endtask

    task automatic start10(input logic [9:0] v, input logic [15:0] bcd);
        @(negedge clk);
        if10.start  = 1'b1;
        if10.bin_in = v;
        push10(bcd);
        @(negedge clk);
        if10.start  = 1'b0;
    endtask

    task automatic start14(input logic [13:0] v, input logic [15:0] bcd_plain,
                           input logic [15:0] bcd_sat, input logic ovf);
        exp_t e;
        @(negedge clk);
        if14.start  = 1'b1;
        if14.bin_in = v;
`ifdef BIN2BCD_OVF_SAT_EN
        e.bcd = bcd_sat; e.ovf = ovf;
`else
        e.bcd = bcd_plain; e.ovf = 1'b0;
`endif
        e.t = cyc + 1;
        q14.push_back(e);
        @(negedge clk);
        if14.start  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q10.size() != 0 || q14.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q10.size() != 0 || q14.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, q10.size() + q14.size());
            q10.delete();
            q14.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        if10.start = 1'b0; if10.bin_in = '0;
        if14.start = 1'b0; if14.bin_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        start10(10'd0, 16'h0000);    drain("zero");
        start10(10'd1023, 16'h1023); drain("max");

        // A start pulse during busy must be dropped, not queued.
        start10(10'd999, 16'h0999);
        repeat (2) @(negedge clk);
        if10.start = 1'b1; if10.bin_in = 10'd5;
        @(negedge clk);
        if10.start = 1'b0;
        drain("ignore");
        repeat (15) @(negedge clk);
        start10(10'd5, 16'h0005);    drain("five");

        // Start held high: second value is accepted in the DONE cycle of the first.
        @(negedge clk);
        if10.start = 1'b1; if10.bin_in = 10'd47;
        push10(16'h0047);
        repeat (11) @(negedge clk);
        if10.bin_in = 10'd512;
        push10(16'h0512);
        @(negedge clk);
        if10.start = 1'b0;
        drain("b2b");

        // Reset lands on the 5th SHIFT edge of a conversion of 777.
        start10(10'd777, 16'h0777);
        repeat (4) @(negedge clk);
        q10.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        start10(10'd777, 16'h0777);  drain("after_rst");

        start14(14'd9999,  16'h9999, 16'h9999, 1'b0); drain("n14_9999");
        start14(14'd12345, 16'h2345, 16'h9999, 1'b1); drain("n14_12345");
        start14(14'd10000, 16'h0000, 16'h9999, 1'b1); drain("n14_10000");
        start14(14'd42,    16'h0042, 16'h0042, 1'b0); drain("n14_42");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
